test_sequencer: RTL
===================

# test_sequencer

Top-level sequencer for one memory-check run. Takes the CSR test parameters, splits the address range into Avalon-MM bursts and feeds them as write and/or read commands to the transmitter. It watches the transmitter and compare block for completion or error, then reports done, pass/fail and progress counters back to the CSR block. It is the sole source of commands into the transmitter, which in turn feeds the compare block.

## Interface
Parameters:
- ADDR_W, 32 – word/byte address width, matching the CSR address fields.
- BURST_W, AMM_BURST_W – burst-count width; maximum burst is 2**(BURST_W-1) words.
- TIMEOUT, 4096 – drain timeout in cycles; must be ≥ 2.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; synchronous, active-high.
- test_start_i  in  1  one-cycle start strobe from CSR.
- test_mode_i  in  2  0 = write only, 1 = read only, 2 = write then read, 3 = reserved (treated as 2).
- start_addr_i  in  ADDR_W  first address, inclusive.
- end_addr_i  in  ADDR_W  last address, inclusive.
- burst_len_i  in  BURST_W  requested burst length; 0 is treated as 1; values above the maximum are clamped to it.
- data_mode_i  in  1  FIX_DATA / RND_DATA; passed through.
- data_ptrn_i  in  8  pattern or LFSR seed; passed through.
- cmd_valid_o  out  1  command valid.
- cmd_ready_i  in  1  transmitter accepts the command.
- cmd_op_o  out  1  0 = write, 1 = read.
- cmd_addr_o  out  ADDR_W  burst start address.
- cmd_words_o  out  BURST_W  burst length minus 1.
- cmd_data_mode_o  out  1  copy of the latched data_mode.
- cmd_data_ptrn_o  out  8  copy of the latched data_ptrn.
- trans_busy_i  in  1  transmitter has outstanding transactions.
- cmp_busy_i  in  1  compare block is busy.
- cmp_error_i  in  1  sticky compare error.
- test_busy_o  out  1  run in progress.
- test_done_o  out  1  one-cycle pulse at end of run.
- test_fail_o  out  1  run ended on compare error; sticky until next start.
- test_timeout_o  out  1  drain timeout occurred; sticky until next start.
- param_err_o  out  1  end_addr_i < start_addr_i at start; sticky until next start.
- wr_burst_cnt_o  out  32  write bursts accepted.
- rd_burst_cnt_o  out  32  read bursts accepted.

Reset values: every output is 0.

## Operation
- States: IDLE, WR_ISSUE, WR_DRAIN, RD_ISSUE, RD_DRAIN, ABORT, DONE.
- IDLE:
  - On test_start_i, latch all parameters and clear counters and sticky flags.
  - If end < start: set param_err_o and go to DONE.
  - Otherwise go to WR_ISSUE (modes 0, 2, 3) or RD_ISSUE (mode 1).
- Range bookkeeping:
  - remaining = end − start + 1, held in ADDR_W+1 bits, so a full-space range does not overflow.
  - Each burst length = min(remaining, clamped burst_len).
  - After each accept: cmd_addr advances by the burst length, remaining decreases by it, and the matching burst counter increments.
- *_ISSUE states:
  - cmd_valid_o stays high until cmd_ready_i.
  - When remaining reaches 0 on an accept, go to *_DRAIN.
- *_DRAIN states:
  - Wait for trans_busy_i = 0 and cmp_busy_i = 0 on two consecutive cycles.
  - WR_DRAIN then goes to RD_ISSUE (mode 2/3) or DONE (mode 0). RD_DRAIN goes to DONE.
  - If TIMEOUT cycles pass without exit: set test_timeout_o and go to DONE.
- Compare error:
  - cmp_error_i high in any non-IDLE state: set test_fail_o and go to ABORT.
  - Drop cmd_valid_o, even mid-handshake; an un-accepted command is discarded.
- ABORT: wait for trans_busy_i = 0 (timeout applies), then go to DONE.
- DONE: assert test_done_o for exactly one cycle, then go to IDLE.
- test_busy_o is high in every state except IDLE.
- The read pass reuses the same start address and pattern, so the compare block regenerates identical data.

## Timing
- All outputs are registered.
- cmd_valid_o rises 1 cycle after the start strobe.
- A new command is presented the cycle after an accept; back-to-back accepts give 1 command per cycle.
- cmd_* fields are stable while cmd_valid_o is high and not yet accepted.
- test_start_i is ignored while test_busy_o = 1.
- Simultaneous cmd_ready_i and cmp_error_i: error wins; the accept is not counted.
- test_fail_o is set the cycle after cmp_error_i is seen.
- rst_i mid-run returns to IDLE next cycle with all outputs 0.
- Counters saturate at 2^32−1.

## Structure
- rtl_settings_pkg:
  - add typedef test_mode_t and the seq_state_t enum;
  - add the TIMEOUT default;
  - reuse AMM_BURST_W, FIX_DATA and RND_DATA.
- One sub-module, burst_splitter:
  - holds the address and remaining registers;
  - computes the next burst length;
  - provides a last_burst flag.

## Test plan
- Mode 2, start 0x100, end 0x10F, burst 4 → 4 writes at 0x100/0x104/0x108/0x10C with words = 3, then 4 reads, done pulse, fail = 0, wr_cnt = rd_cnt = 4.
- Start 0x0, end 0x9, burst 4 → bursts of 4, 4, 2 (words 3, 3, 1).
- cmd_ready_i held low 5 cycles → cmd fields unchanged and no counter increment until accept.
- cmp_error_i pulsed during 2nd read burst → cmd_valid_o drops next cycle, ABORT, done, test_fail_o = 1.
- trans_busy_i stuck high in WR_DRAIN → after TIMEOUT cycles test_timeout_o = 1, done pulse.
- end 0x10 < start 0x20 → param_err_o = 1, done pulse 2 cycles after start, no commands issued.

Source files
------------

// File: rtl/rtl_settings_pkg.sv
// Shared settings for the memory-check datapath: Avalon burst width, data modes
// and the sequencer's mode/state types.
package rtl_settings_pkg;

  localparam int AMM_BURST_W = 8;

  localparam logic FIX_DATA = 1'b0;
  localparam logic RND_DATA = 1'b1;

  localparam int SEQ_TIMEOUT = 4096;

  typedef enum logic [1:0] {
    MODE_WR_ONLY = 2'd0,
    MODE_RD_ONLY = 2'd1,
    MODE_WR_RD   = 2'd2,
    MODE_RSVD    = 2'd3
  } test_mode_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_ISSUE,
    S_WR_DRAIN,
    S_RD_ISSUE,
    S_RD_DRAIN,
    S_ABORT,
    S_DONE
  } seq_state_t;

  function automatic logic is_read_only(input test_mode_t mode);
    return mode == MODE_RD_ONLY;
  endfunction

  // Progress counters stick at all-ones rather than wrapping.
  function automatic logic [31:0] sat_inc32(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/test_sequencer_burst_splitter.sv
// Walks an inclusive address range in bursts of at most the clamped burst length,
// keeping the current burst's address and word count registered.
module burst_splitter
  import rtl_settings_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int BURST_W = AMM_BURST_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              restart,
  input  logic              advance,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  input  logic [BURST_W-1:0] burst_len,
  output logic [ADDR_W-1:0] addr,
  output logic [BURST_W-1:0] words,
  output logic              last_burst
);

  localparam int REM_W = ADDR_W + 1;
  localparam logic [BURST_W-1:0] MAX_LEN = {1'b1, {(BURST_W-1){1'b0}}};

  logic [ADDR_W-1:0]  start_q;
  logic [REM_W-1:0]   range_q;
  logic [REM_W-1:0]   rem_q;
  logic [BURST_W-1:0] len_q;

  logic [REM_W-1:0]   range_new;
  logic [BURST_W-1:0] len_new;
  logic [BURST_W-1:0] cur_len;
  logic [REM_W-1:0]   rem_after;

  function automatic logic [BURST_W-1:0] clamp_len(input logic [BURST_W-1:0] len);
    if (len == '0)
      return BURST_W'(1);
    else if (len > MAX_LEN)
      return MAX_LEN;
    else
      return len;
  endfunction

  function automatic logic [BURST_W-1:0] pick_len(input logic [REM_W-1:0] rem,
                                                  input logic [BURST_W-1:0] len);
    if (rem < REM_W'(len))
      return rem[BURST_W-1:0];
    else
      return len;
  endfunction

  // Word count is length minus one; an exhausted range parks it at zero.
  function automatic logic [BURST_W-1:0] to_words(input logic [BURST_W-1:0] len);
    return (len == '0) ? '0 : len - BURST_W'(1);
  endfunction

  // The extra remaining bit lets a full address-space range be represented.
  assign range_new  = {1'b0, end_addr} - {1'b0, start_addr} + REM_W'(1);
  assign len_new    = clamp_len(burst_len);
  assign cur_len    = words + BURST_W'(1);
  assign rem_after  = rem_q - REM_W'(cur_len);
  assign last_burst = (rem_q == REM_W'(cur_len));

  always_ff @(posedge clk) begin
    if (rst) begin
      start_q <= '0;
      range_q <= '0;
      rem_q   <= '0;
      len_q   <= '0;
      addr    <= '0;
      words   <= '0;
    end else if (load) begin
      start_q <= start_addr;
      range_q <= range_new;
      rem_q   <= range_new;
      len_q   <= len_new;
      addr    <= start_addr;
      words   <= to_words(pick_len(range_new, len_new));
    end else if (restart) begin
      rem_q <= range_q;
      addr  <= start_q;
      words <= to_words(pick_len(range_q, len_q));
    end else if (advance) begin
      rem_q <= rem_after;
      addr  <= addr + ADDR_W'(cur_len);
      words <= to_words(pick_len(rem_after, len_q));
    end
  end

endmodule

// File: rtl/test_sequencer.sv
// Run-level sequencer for a memory check: issues write and/or read bursts to the
// transmitter, drains, and reports completion, failure and burst counts.
module test_sequencer
  import rtl_settings_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int BURST_W = AMM_BURST_W,
  parameter int TIMEOUT = SEQ_TIMEOUT
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               test_start_i,
  input  logic [1:0]         test_mode_i,
  input  logic [ADDR_W-1:0]  start_addr_i,
  input  logic [ADDR_W-1:0]  end_addr_i,
  input  logic [BURST_W-1:0] burst_len_i,
  input  logic               data_mode_i,
  input  logic [7:0]         data_ptrn_i,
  output logic               cmd_valid_o,
  input  logic               cmd_ready_i,
  output logic               cmd_op_o,
  output logic [ADDR_W-1:0]  cmd_addr_o,
  output logic [BURST_W-1:0] cmd_words_o,
  output logic               cmd_data_mode_o,
  output logic [7:0]         cmd_data_ptrn_o,
  input  logic               trans_busy_i,
  input  logic               cmp_busy_i,
  input  logic               cmp_error_i,
  output logic               test_busy_o,
  output logic               test_done_o,
  output logic               test_fail_o,
  output logic               test_timeout_o,
  output logic               param_err_o,
  output logic [31:0]        wr_burst_cnt_o,
  output logic [31:0]        rd_burst_cnt_o
);

  localparam int TO_W = $clog2(TIMEOUT + 1);

  seq_state_t state_q, state_d;
  test_mode_t mode_q;

  logic [TO_W-1:0] drain_cnt_q, drain_cnt_d;
  logic            quiet_q, quiet_d;

  logic        valid_d, op_d, fail_d, timeout_d, param_d;
  logic [31:0] wr_cnt_d, rd_cnt_d;
  logic        load, restart, advance;
  logic        last_burst;
  logic        accept, quiet, drain_expired, in_phase;

  burst_splitter #(
    .ADDR_W  (ADDR_W),
    .BURST_W (BURST_W)
  ) u_splitter (
    .clk        (clk_i),
    .rst        (rst_i),
    .load       (load),
    .restart    (restart),
    .advance    (advance),
    .start_addr (start_addr_i),
    .end_addr   (end_addr_i),
    .burst_len  (burst_len_i),
    .addr       (cmd_addr_o),
    .words      (cmd_words_o),
    .last_burst (last_burst)
  );

  assign accept        = cmd_valid_o && cmd_ready_i;
  assign quiet         = !trans_busy_i && !cmp_busy_i;
  assign drain_expired = (drain_cnt_q == TO_W'(TIMEOUT - 1));
  assign in_phase      = (state_q == S_WR_ISSUE) || (state_q == S_WR_DRAIN) ||
                         (state_q == S_RD_ISSUE) || (state_q == S_RD_DRAIN);

  // A compare error preempts everything, including a same-cycle accept.
  always_comb begin
    state_d     = state_q;
    valid_d     = 1'b0;
    op_d        = cmd_op_o;
    fail_d      = test_fail_o;
    timeout_d   = test_timeout_o;
    param_d     = param_err_o;
    wr_cnt_d    = wr_burst_cnt_o;
    rd_cnt_d    = rd_burst_cnt_o;
    drain_cnt_d = '0;
    quiet_d     = 1'b0;
    load        = 1'b0;
    restart     = 1'b0;
    advance     = 1'b0;

    if (in_phase && cmp_error_i) begin
      fail_d  = 1'b1;
      state_d = S_ABORT;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (test_start_i) begin
            load      = 1'b1;
            fail_d    = 1'b0;
            timeout_d = 1'b0;
            param_d   = 1'b0;
            wr_cnt_d  = '0;
            rd_cnt_d  = '0;
            if (end_addr_i < start_addr_i) begin
              param_d = 1'b1;
              state_d = S_DONE;
            end else if (is_read_only(test_mode_t'(test_mode_i))) begin
              state_d = S_RD_ISSUE;
              valid_d = 1'b1;
              op_d    = 1'b1;
            end else begin
              state_d = S_WR_ISSUE;
              valid_d = 1'b1;
              op_d    = 1'b0;
            end
          end
        end

        S_WR_ISSUE, S_RD_ISSUE: begin
          if (accept) begin
            advance = 1'b1;
            if (state_q == S_WR_ISSUE)
              wr_cnt_d = sat_inc32(wr_burst_cnt_o);
            else
              rd_cnt_d = sat_inc32(rd_burst_cnt_o);
            if (last_burst)
              state_d = (state_q == S_WR_ISSUE) ? S_WR_DRAIN : S_RD_DRAIN;
            else
              valid_d = 1'b1;
          end else begin
            valid_d = 1'b1;
          end
        end

        // Exit needs two consecutive quiet cycles from both downstream blocks.
        S_WR_DRAIN, S_RD_DRAIN: begin
          quiet_d     = quiet;
          drain_cnt_d = drain_cnt_q + TO_W'(1);
          if (quiet && quiet_q) begin
            if ((state_q == S_RD_DRAIN) || (mode_q == MODE_WR_ONLY)) begin
              state_d = S_DONE;
            end else begin
              restart = 1'b1;
              state_d = S_RD_ISSUE;
              valid_d = 1'b1;
              op_d    = 1'b1;
            end
          end else if (drain_expired) begin
            timeout_d = 1'b1;
            state_d   = S_DONE;
          end
        end

        S_ABORT: begin
          drain_cnt_d = drain_cnt_q + TO_W'(1);
          if (!trans_busy_i) begin
            state_d = S_DONE;
          end else if (drain_expired) begin
            timeout_d = 1'b1;
            state_d   = S_DONE;
          end
        end

        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q         <= S_IDLE;
      mode_q          <= MODE_WR_ONLY;
      drain_cnt_q     <= '0;
      quiet_q         <= 1'b0;
      cmd_valid_o     <= 1'b0;
      cmd_op_o        <= 1'b0;
      cmd_data_mode_o <= FIX_DATA;
      cmd_data_ptrn_o <= '0;
      test_busy_o     <= 1'b0;
      test_done_o     <= 1'b0;
      test_fail_o     <= 1'b0;
      test_timeout_o  <= 1'b0;
      param_err_o     <= 1'b0;
      wr_burst_cnt_o  <= '0;
      rd_burst_cnt_o  <= '0;
    end else begin
      state_q        <= state_d;
      drain_cnt_q    <= drain_cnt_d;
      quiet_q        <= quiet_d;
      cmd_valid_o    <= valid_d;
      cmd_op_o       <= op_d;
      test_busy_o    <= (state_d != S_IDLE);
      test_done_o    <= (state_q == S_DONE);
      test_fail_o    <= fail_d;
      test_timeout_o <= timeout_d;
      param_err_o    <= param_d;
      wr_burst_cnt_o <= wr_cnt_d;
      rd_burst_cnt_o <= rd_cnt_d;
      if (load) begin
        mode_q          <= test_mode_t'(test_mode_i);
        cmd_data_mode_o <= data_mode_i;
        cmd_data_ptrn_o <= data_ptrn_i;
      end
    end
  end

endmodule
